// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single unified instruction/data memory port between the CPU and
// a DMA/loader master. The CPU wins by default. A starvation counter makes sure
// a waiting DMA master gets a grant at least once every MAX_HOLD+1 grants.
// Each access runs a fixed four-state sequence that fits a synchronous-read
// memory:
//   IDLE   -> pick a winner and latch its request into the mem_* registers
//   ACCESS -> mem_en is high; mem_we is the latched write flag
//   RESP   -> mem_rdata is valid and is captured for reads
//   DONE   -> the owner's ack is high for this one cycle
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   cpu_req/we/addr/wdata       CPU request; held stable until cpu_ack
//   cpu_ack, cpu_rdata          CPU completion pulse and held read data
//   dma_req/we/addr/wdata       DMA request; held stable until dma_ack
//   dma_ack, dma_rdata          DMA completion pulse and held read data
//   mem_en/we/addr/wdata        registered memory port controls
//   mem_rdata                   memory read data, valid one cycle after mem_en
//   busy                        high whenever the sequencer is not in IDLE
//   owner                       current or last grantee (0 = CPU, 1 = DMA)
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t     state;
  logic [3:0] streak;    // consecutive CPU grants taken while DMA was waiting
  logic       is_write;  // latched we of the access in flight
  logic       pick_dma;

  // DMA wins when it is alone, or when the CPU has used up its hold allowance.
  always_comb begin
    pick_dma = dma_req && (!cpu_req || (streak == HOLD_LIMIT));
  end

  assign busy = (state != IDLE);

  // NOTE: every register here is assigned with <= so that all of them see the
  // values from before the clock edge; blocking assignments would make the
  // result depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      is_write  <= 1'b0;
      owner     <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Pulses default low so each is high for exactly one state.
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;

      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            state  <= ACCESS;
            owner  <= pick_dma;
            mem_en <= 1'b1;
            if (pick_dma) begin
              mem_we    <= dma_we;
              is_write  <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
              streak    <= '0;
            end else begin
              mem_we    <= cpu_we;
              is_write  <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              // The streak only grows while DMA is actually left waiting.
              if (!dma_req) begin
                streak <= '0;
              end else if (streak != 4'hF) begin
                streak <= streak + 4'd1;
              end
            end
          end
        end

        ACCESS: state <= RESP;

        RESP: begin
          // Capture read data and raise ack here so both show up in DONE.
          if (!is_write) begin
            if (owner) dma_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
          end
          if (owner) dma_ack <= 1'b1;
          else       cpu_ack <= 1'b1;
          state <= DONE;
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a randomized
// two-master run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, owner;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .dma_req  (dma_req),
    .dma_we   (dma_we),
    .dma_addr (dma_addr),
    .dma_wdata(dma_wdata),
    .dma_ack  (dma_ack),
    .dma_rdata(dma_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .owner    (owner)
  );

  // Power-on memory contents, indexed by the low address byte.
  function automatic logic [DW-1:0] init_word(input logic [7:0] idx);
    if (idx == 8'h10) return 32'hDEAD_BEEF;
    return {idx, ~idx, idx ^ 8'h5A, 8'hC3};
  endfunction

  // Synchronous-read memory emulator driven by the DUT's memory port.
  logic [DW-1:0] mem [256];
  logic [255:0]  mem_written = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[7:0]]         <= mem_wdata;
        mem_written[mem_addr[7:0]] <= 1'b1;
      end else begin
        mem_rdata <= mem_written[mem_addr[7:0]] ? mem[mem_addr[7:0]]
                                                : init_word(mem_addr[7:0]);
      end
    end
  end

  // Reference copy of what memory should contain.
  logic [DW-1:0] ref_mem [256];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Steps at least once, then until either ack is seen or the budget runs out.
  task automatic wait_ack(output logic who, output int waited);
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (!(cpu_ack || dma_ack) && waited < 12);
    who = dma_ack;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    cycle();
    cycle();
    n_total++;
    if ({cpu_ack, dma_ack, mem_en, mem_we, busy, owner} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000",
               {cpu_ack, dma_ack, mem_en, mem_we, busy, owner});
    else n_pass++;
    n_total++;
    if ({cpu_rdata, dma_rdata} !== '0)
      $display("FAIL reset_rdata: got %h/%h expected 0/0", cpu_rdata, dma_rdata);
    else n_pass++;
    n_total++;
    if ({mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_mem: got %h/%h expected 0/0", mem_addr, mem_wdata);
    else n_pass++;
    reset = 1'b0;
    cycle();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_cpu_read();
    cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = $urandom; cpu_req = 1;
    cycle();  // N+1
    n_total++;
    if ({mem_en, mem_we, mem_addr, busy} !== {2'b10, 32'h10, 1'b1})
      $display("FAIL cpu_read_access: got en=%b we=%b addr=%h busy=%b expected 1 0 10 1",
               mem_en, mem_we, mem_addr, busy);
    else n_pass++;
    cycle();  // N+2
    n_total++;
    if (mem_en !== 1'b0) $display("FAIL cpu_read_en_pulse: got %b expected 0", mem_en);
    else n_pass++;
    cycle();  // N+3
    n_total++;
    if ({cpu_ack, dma_ack} !== 2'b10)
      $display("FAIL cpu_read_ack: got cpu=%b dma=%b expected 1 0", cpu_ack, dma_ack);
    else n_pass++;
    n_total++;
    if (cpu_rdata !== 32'hDEAD_BEEF)
      $display("FAIL cpu_read_data: got %h expected deadbeef", cpu_rdata);
    else n_pass++;
    cpu_req = 0;
    repeat (3) cycle();
    n_total++;
    if ({cpu_ack, dma_ack, busy, cpu_rdata} !== {3'b000, 32'hDEAD_BEEF})
      $display("FAIL cpu_read_hold: got ack=%b%b busy=%b rdata=%h expected 00 0 deadbeef",
               cpu_ack, dma_ack, busy, cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_dma_write();
    logic [DW-1:0] prev;
    prev = dma_rdata;
    dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678; dma_req = 1;
    ref_mem[8'h20] = 32'h1234_5678;
    cycle();  // N+1
    n_total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, owner} !== {2'b11, 32'h20, 32'h1234_5678, 1'b1})
      $display("FAIL dma_write_access: got en=%b we=%b addr=%h wdata=%h owner=%b expected 1 1 20 12345678 1",
               mem_en, mem_we, mem_addr, mem_wdata, owner);
    else n_pass++;
    cycle();
    cycle();  // N+3
    n_total++;
    if ({cpu_ack, dma_ack} !== 2'b01)
      $display("FAIL dma_write_ack: got cpu=%b dma=%b expected 0 1", cpu_ack, dma_ack);
    else n_pass++;
    n_total++;
    if (dma_rdata !== prev)
      $display("FAIL dma_write_rdata: got %h expected %h", dma_rdata, prev);
    else n_pass++;
    dma_req = 0;
    cycle();
    n_total++;
    if (mem[8'h20] !== 32'h1234_5678)
      $display("FAIL dma_write_mem: got %h expected 12345678", mem[8'h20]);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic who;
    int   waited;
    logic exp_who;
    cpu_we = 0; cpu_addr = 32'h10;
    dma_we = 0; dma_addr = 32'h20;
    cpu_req = 1; dma_req = 1;
    for (int i = 0; i < 10; i++) begin
      exp_who = (i == 4) || (i == 9);
      wait_ack(who, waited);
      n_total++;
      if ({cpu_ack, dma_ack, waited} !== {~exp_who, exp_who, ((i == 0) ? 32'd3 : 32'd4)})
        $display("FAIL contention_grant%0d: got cpu=%b dma=%b after %0d cycles expected cpu=%b dma=%b after %0d",
                 i, cpu_ack, dma_ack, waited, ~exp_who, exp_who, (i == 0) ? 3 : 4);
      else n_pass++;
      if (exp_who) begin
        n_total++;
        if (dma_rdata !== 32'h1234_5678)
          $display("FAIL contention_dma_data: got %h expected 12345678", dma_rdata);
        else n_pass++;
      end
    end
    cpu_req = 0; dma_req = 0;
    cycle();
  endtask

  task automatic test_simultaneous();
    logic who;
    int   waited;
    cpu_we = 0; cpu_addr = 32'h20;
    dma_we = 0; dma_addr = 32'h10;
    cpu_req = 1; dma_req = 1;
    wait_ack(who, waited);
    n_total++;
    if ({cpu_ack, dma_ack, owner, waited} !== {3'b100, 32'd3})
      $display("FAIL simul_first: got cpu=%b dma=%b owner=%b after %0d expected 1 0 0 after 3",
               cpu_ack, dma_ack, owner, waited);
    else n_pass++;
    cpu_req = 0;
    wait_ack(who, waited);
    n_total++;
    if ({cpu_ack, dma_ack, owner, waited} !== {3'b011, 32'd4})
      $display("FAIL simul_second: got cpu=%b dma=%b owner=%b after %0d expected 0 1 1 after 4",
               cpu_ack, dma_ack, owner, waited);
    else n_pass++;
    n_total++;
    if ({cpu_rdata, dma_rdata} !== {32'h1234_5678, 32'hDEAD_BEEF})
      $display("FAIL simul_data: got %h/%h expected 12345678/deadbeef", cpu_rdata, dma_rdata);
    else n_pass++;
    dma_req = 0;
    cycle();
  endtask

  task automatic test_late_request();
    logic          who;
    int            waited;
    logic [DW-1:0] d;
    cpu_we = 0; cpu_addr = 32'h10; cpu_req = 1;
    cycle();  // ACCESS of the CPU access
    d = $urandom;
    dma_we = 1; dma_addr = 32'h30; dma_wdata = d; dma_req = 1;
    ref_mem[8'h30] = d;
    n_total++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h10})
      $display("FAIL late_access: got en=%b addr=%h expected 1 10", mem_en, mem_addr);
    else n_pass++;
    wait_ack(who, waited);
    n_total++;
    if ({cpu_ack, dma_ack, waited} !== {2'b10, 32'd2})
      $display("FAIL late_cpu_ack: got cpu=%b dma=%b after %0d expected 1 0 after 2",
               cpu_ack, dma_ack, waited);
    else n_pass++;
    cpu_req = 0;
    wait_ack(who, waited);
    n_total++;
    if ({cpu_ack, dma_ack, waited} !== {2'b01, 32'd4})
      $display("FAIL late_dma_ack: got cpu=%b dma=%b after %0d expected 0 1 after 4",
               cpu_ack, dma_ack, waited);
    else n_pass++;
    dma_req = 0;
    cycle();
    n_total++;
    if (mem[8'h30] !== d) $display("FAIL late_dma_mem: got %h expected %h", mem[8'h30], d);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic who;
    int   waited;
    cpu_we = 0; cpu_addr = 32'h40; cpu_req = 1;
    cycle();  // ACCESS
    cycle();  // RESP
    reset = 1'b1;
    cycle();
    n_total++;
    if ({cpu_ack, dma_ack, mem_en, mem_we, busy, owner} !== 6'b0)
      $display("FAIL rst_mid_ctrl: got %b expected 000000",
               {cpu_ack, dma_ack, mem_en, mem_we, busy, owner});
    else n_pass++;
    n_total++;
    if ({cpu_rdata, dma_rdata, mem_addr, mem_wdata} !== '0)
      $display("FAIL rst_mid_data: got rdata=%h/%h mem=%h/%h expected all 0",
               cpu_rdata, dma_rdata, mem_addr, mem_wdata);
    else n_pass++;
    reset = 1'b0;
    wait_ack(who, waited);
    n_total++;
    if ({cpu_ack, dma_ack, waited} !== {2'b10, 32'd3})
      $display("FAIL rst_mid_retry: got cpu=%b dma=%b after %0d expected 1 0 after 3",
               cpu_ack, dma_ack, waited);
    else n_pass++;
    n_total++;
    if (cpu_rdata !== ref_mem[8'h40])
      $display("FAIL rst_mid_data_after: got %h expected %h", cpu_rdata, ref_mem[8'h40]);
    else n_pass++;
    cpu_req = 0;
    cycle();
  endtask

  // Transaction-level model: a grant starts an access whose ack arrives three
  // cycles later and the port is free again one cycle after that.
  task automatic test_random();
    bit            have = 0;
    int            gk = 0;
    int            idle_at = 0;
    int            streak = 0;
    logic          t_who = 0, t_we = 0, m_owner = 0;
    logic [AW-1:0] t_addr = '0;
    logic [DW-1:0] t_wdata = '0, t_rdata = '0;
    logic [DW-1:0] m_cpu_rdata, m_dma_rdata;
    logic [4:0]    exp_ctrl;
    m_cpu_rdata = ref_mem[8'h40];
    m_dma_rdata = '0;
    for (int k = 0; k < 800; k++) begin
      // Expected outputs in this cycle from the access in flight.
      if (have && k == gk + 3 && !t_we) begin
        if (t_who) m_dma_rdata = t_rdata;
        else       m_cpu_rdata = t_rdata;
      end
      exp_ctrl = {have && k == gk + 3 && !t_who, have && k == gk + 3 && t_who,
                  have && k == gk + 1, have && k > gk && k <= gk + 3, m_owner};
      n_total++;
      if ({cpu_ack, dma_ack, mem_en, busy, owner} !== exp_ctrl)
        $display("FAIL rand_ctrl@%0d: got ack=%b%b en=%b busy=%b owner=%b expected %b",
                 k, cpu_ack, dma_ack, mem_en, busy, owner, exp_ctrl);
      else n_pass++;
      if (have && k == gk + 1) begin
        n_total++;
        if ({mem_we, mem_addr, mem_wdata} !== {t_we, t_addr, t_wdata})
          $display("FAIL rand_port@%0d: got we=%b addr=%h wdata=%h expected %b %h %h",
                   k, mem_we, mem_addr, mem_wdata, t_we, t_addr, t_wdata);
        else n_pass++;
      end
      n_total++;
      if ({cpu_rdata, dma_rdata} !== {m_cpu_rdata, m_dma_rdata})
        $display("FAIL rand_rdata@%0d: got %h/%h expected %h/%h",
                 k, cpu_rdata, dma_rdata, m_cpu_rdata, m_dma_rdata);
      else n_pass++;

      // Masters: hold until ack, then drop or reissue; otherwise maybe start.
      if (cpu_req ? (cpu_ack && $urandom_range(1) == 0) : 1'b0) cpu_req = 0;
      else if ((cpu_req && cpu_ack) || (!cpu_req && $urandom_range(2) == 0)) begin
        cpu_req = 1; cpu_we = $urandom_range(1); cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (dma_req ? (dma_ack && $urandom_range(1) == 0) : 1'b0) dma_req = 0;
      else if ((dma_req && dma_ack) || (!dma_req && $urandom_range(2) == 0)) begin
        dma_req = 1; dma_we = $urandom_range(1); dma_addr = $urandom; dma_wdata = $urandom;
      end

      // Grant decision when the port is free.
      if (k >= idle_at && (cpu_req || dma_req)) begin
        t_who = dma_req && (!cpu_req || streak == MAX_HOLD);
        if (t_who) begin
          streak = 0;
          t_we = dma_we; t_addr = dma_addr; t_wdata = dma_wdata;
        end else begin
          streak = dma_req ? ((streak == 15) ? 15 : streak + 1) : 0;
          t_we = cpu_we; t_addr = cpu_addr; t_wdata = cpu_wdata;
        end
        if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
        else      t_rdata = ref_mem[t_addr[7:0]];
        have = 1; gk = k; idle_at = k + 4; m_owner = t_who;
      end
      cycle();
    end
    cpu_req = 0; dma_req = 0;
    repeat (6) cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_contention();
    test_simultaneous();
    test_late_request();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

endmodule
